uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NREQ byte-stream requesters (CPU console, debug monitor, trace unit, ...).
- Arbitrates round-robin at message granularity: a requester keeps the UART until it marks a byte last, hits MAX_BURST bytes, or goes idle for HOLD_TIMEOUT cycles.
- Sits between the requesters and the UART data-register write port (dat_we / dat_di / dat_wait handshake); the UART itself is unchanged.

---
 rtl/uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART data-register write port between NREQ
// byte-stream requesters. Round-robin at message granularity: a holder keeps
// the UART until it flags a byte last, reaches MAX_BURST bytes, or stays idle
// for HOLD_TIMEOUT cycles.
// Optional build macro UART_ARB_TAG_EN: every grant is prefixed with the two
// tag bytes '0'+id and ':' sent through the normal write handshake.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_dat_we,
  output logic [31:0]       uart_dat_di,
  input  logic              uart_dat_wait,
  output logic              grant_valid,
  output logic [2:0]        grant_id,
  output logic              busy
);

  localparam logic [7:0]  BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SEND    = 3'd2,
    HOLD    = 3'd3
`ifdef UART_ARB_TAG_EN
    ,
    TAG0    = 3'd4,
    TAG1    = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        grant_valid_q, grant_valid_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;

  logic            cur_valid_s;
  logic [7:0]      cur_data_s;
  logic            cur_last_s;
  logic [2:0]      pick_s;
  logic            release_s;
  logic [NREQ-1:0] req_ready_s;

  // First requester with valid set at or after ptr, wrapping to the lowest index.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] v, input logic [2:0] ptr);
    logic [2:0] sel;
    sel = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) sel = 3'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i] && (3'(i) >= ptr)) sel = 3'(i);
    end
    return sel;
  endfunction

  // Pointer to the requester after id, modulo NREQ.
  function automatic logic [2:0] next_ptr(input logic [2:0] id);
    return (id >= 3'(NREQ - 1)) ? 3'd0 : id + 3'd1;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [2:0] id);
    logic [NREQ-1:0] oh;
    for (int i = 0; i < NREQ; i++) oh[i] = (id == 3'(i));
    return oh;
  endfunction

  // Mux out the current holder's request lines and the next arbitration winner.
  always_comb begin
    cur_valid_s = 1'b0;
    cur_data_s  = 8'h00;
    cur_last_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cur_valid_s = cur_valid_s | (req_valid[i] & (grant_id_q == 3'(i)));
      cur_last_s  = cur_last_s  | (req_last[i]  & (grant_id_q == 3'(i)));
      cur_data_s  = cur_data_s  | (req_data[8*i +: 8] & {8{grant_id_q == 3'(i)}});
    end
    pick_s = rr_pick(req_valid, rr_ptr_q);
  end

  // Next-state logic for the grant FSM, counters and latched byte.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    byte_d        = byte_q;
    last_d        = last_q;
    release_s     = 1'b0;
    req_ready_s   = {NREQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_id_d    = pick_s;
          grant_valid_d = 1'b1;
`ifdef UART_ARB_TAG_EN
          state_d       = TAG0;
          byte_d        = 8'h30 + {5'b00000, pick_s};
`else
          state_d       = CAPTURE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG0: begin
        if (!uart_dat_wait) begin
          byte_d  = 8'h3A;
          state_d = TAG1;
        end else begin
          state_d = TAG0;
        end
      end
      TAG1: begin
        if (!uart_dat_wait) begin
          state_d = CAPTURE;
        end else begin
          state_d = TAG1;
        end
      end
`endif
      CAPTURE: begin
        if (cur_valid_s) begin
          byte_d      = cur_data_s;
          last_d      = cur_last_s;
          req_ready_s = onehot(grant_id_q);
          burst_cnt_d = (burst_cnt_q < BURST_LIMIT) ? burst_cnt_q + 8'd1 : burst_cnt_q;
          state_d     = SEND;
        end else begin
          state_d = HOLD;
        end
      end
      SEND: begin
        if (!uart_dat_wait) begin
          if (last_q || (burst_cnt_q == BURST_LIMIT)) begin
            release_s = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          state_d = SEND;
        end
      end
      HOLD: begin
        if (cur_valid_s) begin
          idle_cnt_d = 16'd0;
          state_d    = CAPTURE;
        end else if (idle_cnt_q >= HOLD_LAST) begin
          release_s = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      default: begin
        release_s = 1'b1;
      end
    endcase
    // Release hands the UART back and moves the round-robin pointer past the holder.
    if (release_s) begin
      state_d       = IDLE;
      grant_valid_d = 1'b0;
      rr_ptr_d      = next_ptr(grant_id_q);
      burst_cnt_d   = 8'd0;
      idle_cnt_d    = 16'd0;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
`ifdef UART_ARB_TAG_EN
    we_d   = (state_d == SEND) || (state_d == TAG0) || (state_d == TAG1);
`else
    we_d   = (state_d == SEND);
`endif
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the write strobe and discards the latched byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 3'd0;
      rr_ptr_q      <= 3'd0;
      burst_cnt_q   <= 8'd0;
      idle_cnt_q    <= 16'd0;
      byte_q        <= 8'h00;
      last_q        <= 1'b0;
      we_q          <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      we_q          <= we_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_s;
  assign uart_dat_we = we_q;
  assign uart_dat_di = {24'h000000, byte_q};
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester models feed byte queues,
// every UART write is popped from a scoreboard of expected bytes.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int MB   = 4;
  localparam int HT   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              uart_dat_we;
  logic [31:0]       uart_dat_di;
  logic              uart_dat_wait = 1'b0;
  logic              grant_valid;
  logic [2:0]        grant_id;
  logic              busy;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di), .uart_dat_wait(uart_dat_wait),
    .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic [8:0] src_mem [NREQ][32];
  int         src_head [NREQ];
  int         src_tail [NREQ];
  int         rdy_cnt [NREQ];
  logic       s_gv, s_we, acc_flag;
  logic [2:0] s_gid;
  logic [31:0] s_di;
  logic [7:0] acc_byte;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NREQ; i++) if (src_head[i] < src_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
        req_last[i]        = src_mem[i][src_head[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int id, input logic [7:0] b, input logic l);
    src_mem[id][src_tail[id]] = {l, b};
    src_tail[id]++;
    drive_srcs();
  endtask

  // Expected tag prefix of a grant (only in the tagged build).
  task automatic exp_grant(input int id);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'h30 + 8'(id));
    exp_q.push_back(8'h3A);
`else
    if (id < 0) exp_q.delete();
`endif
  endtask

  // One clock: monitor at the falling edge, then let requesters react after the rising edge.
  task automatic step();
    logic [NREQ-1:0] rdy;
    logic [7:0] eb;
    @(negedge clk);
    rdy = req_ready;
    s_gv = grant_valid; s_gid = grant_id; s_we = uart_dat_we; s_di = uart_dat_di;
    acc_flag = 1'b0;
    if (!reset) begin
      checks++;
      assert ($onehot0(rdy) && ((rdy & ~req_valid) == '0)) else begin
        errors++;
        $error("FAIL ready_onehot observed %b expected one-hot within valid %b", rdy, req_valid);
      end
      if (uart_dat_we && !uart_dat_wait) begin
        acc_flag = 1'b1;
        acc_byte = uart_dat_di[7:0];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL uart_write observed %0h expected no write", uart_dat_di);
        end else begin
          eb = exp_q.pop_front();
          assert (uart_dat_di === {24'h0, eb}) else begin
            errors++;
            $error("FAIL uart_write observed %0h expected %0h", uart_dat_di, {24'h0, eb});
          end
        end
      end
    end
    for (int i = 0; i < NREQ; i++) if (rdy[i]) rdy_cnt[i]++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (rdy[i]) src_head[i]++;
    drive_srcs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    uart_dat_wait = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0; src_tail[i] = 0; rdy_cnt[i] = 0;
    end
    drive_srcs();
    step(); step();
    reset = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(exp_q.size() == 0 && srcs_empty() && !busy) && n < max_cycles);
    checks++;
    assert (exp_q.size() == 0 && srcs_empty() && !busy) else begin
      errors++;
      $error("FAIL %s observed pending=%0d busy=%0b expected 0 0 within %0d cycles",
             tag, exp_q.size(), busy, max_cycles);
    end
  endtask

  initial begin
    int n;
    int hold_cnt;
    do_reset();
    chk(32'(uart_dat_we), 32'h0, "rst_we");
    chk(32'(grant_valid), 32'h0, "rst_gv");
    chk(32'(grant_id), 32'h0, "rst_gid");
    chk(32'(busy), 32'h0, "rst_busy");
    chk(32'(req_ready), 32'h0, "rst_ready");
    chk(uart_dat_di, 32'h0, "rst_di");

    // Single requester 2, then check the pointer moved to 3.
    push_src(2, 8'h48, 1'b0); push_src(2, 8'h69, 1'b1);
    exp_grant(2); exp_q.push_back(8'h48); exp_q.push_back(8'h69);
    run_until_idle(100, "single_done");
    chk(32'(rdy_cnt[2]), 32'd2, "single_ready_cnt");
    chk(32'(grant_valid), 32'h0, "single_gv_drop");
    push_src(0, 8'hB0, 1'b1); push_src(3, 8'hB3, 1'b1);
    exp_grant(3); exp_q.push_back(8'hB3);
    exp_grant(0); exp_q.push_back(8'hB0);
    run_until_idle(100, "rrptr_done");

    // Round-robin with all requesters continuously valid.
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NREQ; i++) begin
        push_src(i, 8'hA0 + 8'(i), 1'b1);
        exp_grant(i); exp_q.push_back(8'hA0 + 8'(i));
      end
    run_until_idle(300, "rr_done");

    // Burst limit: requester 1 streams 10 bytes without last, requester 3 waits.
    do_reset();
    for (int k = 0; k < 10; k++) push_src(1, 8'h10 + 8'(k), 1'b0);
    push_src(3, 8'hC0, 1'b0); push_src(3, 8'hC1, 1'b1);
    exp_grant(1); for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
    exp_grant(3); exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    exp_grant(1); for (int k = 4; k < 8; k++) exp_q.push_back(8'h10 + 8'(k));
    exp_grant(1); exp_q.push_back(8'h18); exp_q.push_back(8'h19);
    run_until_idle(400, "burst_done");
    chk(32'(rdy_cnt[1]), 32'd10, "burst_ready1");
    chk(32'(rdy_cnt[3]), 32'd2, "burst_ready3");

    // Timeout: requester 0 goes idle after one byte; requester 1 waits its turn.
    do_reset();
    push_src(0, 8'h50, 1'b0); push_src(1, 8'h51, 1'b1);
    exp_grant(0); exp_q.push_back(8'h50);
    exp_grant(1); exp_q.push_back(8'h51);
    n = 0;
    do begin step(); n++; end while (!(acc_flag && acc_byte == 8'h50) && n < 50);
    chk(32'(acc_byte), 32'h50, "to_first_byte");
    hold_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (s_gv && s_gid == 3'd0) hold_cnt++;
      else break;
    end
    chk(32'(hold_cnt), 32'd9, "to_capture_plus_hold");
    chk(32'(s_gv), 32'h0, "to_release_gv");
    run_until_idle(100, "to_done");

    // Backpressure: strobe and data stay put while wait is high.
    do_reset();
    push_src(1, 8'h61, 1'b1); exp_grant(1); exp_q.push_back(8'h61);
    run_until_idle(100, "bp_pre_done");
    uart_dat_wait = 1'b1;
    push_src(2, 8'h62, 1'b1); exp_grant(2); exp_q.push_back(8'h62);
    n = 0;
    do begin step(); n++; end while (!s_we && n < 20);
    chk(32'(s_we), 32'h1, "bp_we_seen");
    for (int k = 0; k < 50; k++) begin
      step();
      chk(32'(s_we), 32'h1, "bp_we_stable");
      chk(s_di, {24'h0, exp_q[0]}, "bp_di_stable");
    end
    uart_dat_wait = 1'b0;
    run_until_idle(100, "bp_done");

    // Reset while stalled in a write; requester 0 must win afterwards.
    uart_dat_wait = 1'b1;
    push_src(3, 8'h73, 1'b1); push_src(0, 8'h70, 1'b1);
    n = 0;
    do begin step(); n++; end while (!s_we && n < 20);
    chk(32'(s_we), 32'h1, "rst_mid_we_seen");
    repeat (19) step();
    reset = 1'b1;
    step();
    chk(32'(uart_dat_we), 32'h0, "rst_mid_we");
    chk(32'(grant_valid), 32'h0, "rst_mid_gv");
    chk(32'(busy), 32'h0, "rst_mid_busy");
    reset = 1'b0;
    uart_dat_wait = 1'b0;
    if (src_head[3] >= src_tail[3]) push_src(3, 8'h74, 1'b1);
    exp_grant(0); exp_q.push_back(8'h70);
    exp_grant(3); exp_q.push_back(src_mem[3][src_head[3]][7:0]);
    run_until_idle(100, "rst_after_done");

    // Single-byte message from requester 3 (tags prepended in the tagged build).
    do_reset();
    push_src(3, 8'h41, 1'b1);
    exp_grant(3); exp_q.push_back(8'h41);
    run_until_idle(100, "tag_done");
    chk(32'(rdy_cnt[3]), 32'd1, "tag_ready_once");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
